serial_adder: RTL



---
 rtl/adder_pkg.sv | 21 ++
 rtl/chunk_adder.sv | 31 +++
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and sizing helpers for the serial adder.
package adder_pkg;

  // Controller states of the serial adder
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Number of compute cycles needed for one operation
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Width of the chunk index counter (at least one bit)
  function automatic int calc_idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder built from full adders.
// cmsb is the carry into the most significant bit, used for signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c_s[i]),
      .sum  (sum[i]),
      .cout (c_s[i+1])
    );
  end

  assign cout = c_s[CHUNK];
  assign cmsb = c_s[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit combinational full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder processing CHUNK bits per clock,
// with valid/ready handshakes on operands and result.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed overflow
// output ovf.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDXW   = calc_idx_w(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [CHUNK-1:0]  a_chunk_s;
  logic [CHUNK-1:0]  b_chunk_s;
  logic [CHUNK-1:0]  chunk_sum_s;
  logic              chunk_cout_s;
  logic              chunk_cmsb_s;

  // Current slice of the captured operands
  assign a_chunk_s = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk_s = b_q[idx_q*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (carry_q),
    .sum  (chunk_sum_s),
    .cout (chunk_cout_s),
    .cmsb (chunk_cmsb_s)
  );

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow of the final chunk, held alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == CALC) && (idx_q == LAST_IDX)) begin
      ovf_q <= chunk_cout_s ^ chunk_cmsb_s;
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_cmsb_s;
  assign unused_cmsb_s = chunk_cmsb_s;
`endif

  // Controller, operand/result/carry registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          sum_q[idx_q*CHUNK +: CHUNK] <= chunk_sum_s;
          carry_q <= chunk_cout_s;
          if (idx_q == LAST_IDX) begin
            // Park the index at zero so the operand slice stays in range
            idx_q       <= '0;
            cout_q      <= chunk_cout_s;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_ONE;
          end
        end
        DONE: begin
          // in_ready rises only after DONE is left, so no same-cycle accept
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          idx_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule
